regread_arbiter: RTL and testbench
==================================

# regread_arbiter

Round-robin arbiter and sequencer that shares one 32-entry, 32-bit register-file read port between four requesters. It drives the 5-bit select of the 32-to-1 read multiplexer from a register, captures the multiplexer output one cycle later, and returns the data to the winning requester. It sits between the register-file storage/mux and the pipeline units that need register operands, such as decode, debug dump and the scoreboard.

## Interface
Parameters:
- NREQ, 4: number of requesters (fixed at 4 in this revision; requester index is 2 bits)
- ADDR_W, 5: register address width
- DATA_W, 32: register data width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester read request; held high until granted
- addr  input  NREQ*ADDR_W  per-requester register address; requester i uses bits [i*5+4 : i*5]; stable while req[i] is high
- gnt  output  NREQ  one-hot combinational grant; transfer occurs when req[i] & gnt[i]
- Select  output  ADDR_W  registered select to the read mux
- MuxOut  input  DATA_W  combinational output of the read mux
- rdata  output  DATA_W  registered read data
- rvalid  output  NREQ  one-hot; rvalid[i] high for exactly 1 cycle when rdata belongs to requester i

## Operation
- Each cycle, at most one request is granted.
- Priority search starts at pointer ptr and scans ptr, ptr+1, … mod 4. The first requester with req high wins.
- gnt is all-zero when no req is high or when reset is high.
- On a grant to requester i:
  - Select ← addr[i]
  - owner ← i
  - pend ← 1
  - ptr ← (i+1) mod 4, so requester 3 wraps to 0
- With no grant: Select and ptr hold their values, and pend ← 0.
- Pipeline stage 2: if pend is high, rdata ← MuxOut and rvalid ← onehot(owner). Otherwise rvalid ← 0 and rdata holds.
- Back-to-back operation: a requester keeping req high after a grant is treated as a new request. It competes again and has lowest priority next cycle, because ptr has moved past it.
- Throughput is one read per cycle. No stall input exists, and consumers must accept rvalid unconditionally.
- Reset values: Select = 0, ptr = 0 (requester 0 first), owner = 0, pend = 0, rdata = 0, rvalid = 0.
- Reset mid-operation: in-flight reads are discarded. rvalid is 0 on the cycle after reset is sampled, and no late rvalid appears after reset deasserts.

## Timing
- Cycle t: req[i] high and i wins, so gnt[i] = 1 combinationally in cycle t.
- Edge t→t+1: Select is updated. MuxOut is valid within cycle t+1 (purely combinational path).
- Edge t+1→t+2: rdata and rvalid[i] are registered, so they are visible in cycle t+2.
- Latency from grant to data is 2 cycles.
- Simultaneous request from all four requesters with ptr = 0: grants go 0, 1, 2, 3, 0, … on consecutive cycles.
- A request arriving while another requester is granted waits. Worst case is 3 cycles of wait before its grant.
- A req dropped before grant is legal and has no side effects.

## Structure
- Shared package regfile_pkg:
  - ADDR_W = 5, DATA_W = 32, NREQ = 4
  - requester-index type (2 bits)
  - register-address type (5 bits)
- Sub-module rr_picker: combinational.
  - Inputs: req[3:0], ptr[1:0]
  - Outputs: one-hot gnt and encoded winner index
  - Reusable by future write-port arbitration.
- The top-level holds:
  - ptr, Select, owner and pend registers
  - rdata/rvalid output registers
  - addr slice mux.

## Test plan
- Reset then single request: reset 2 cycles, preload reg 7 = 0xDEADBEEF in the mux model, req[2] = 1, addr[2] = 7.
  - gnt = 0100 same cycle; Select = 7 next cycle.
  - rdata = 0xDEADBEEF with rvalid = 0100 two cycles after grant; Select = 0 and rvalid = 0 during reset.
- Full contention: req = 1111 held 8 cycles with addrs 1, 2, 3, 4, starting from ptr = 0.
  - Grants 0001, 0010, 0100, 1000, repeating; rvalid follows 2 cycles behind.
  - rdata equals reg[1], reg[2], reg[3], reg[4], repeating.
- Pointer wrap/fairness: grant req[3] alone, then assert req = 1001.
  - Next grant is req[0] (ptr wrapped to 0), then req[3].
- Idle hold: after a read of reg 31, drop all req for 5 cycles.
  - Select stays 31, gnt = 0 and rvalid = 0 throughout; rdata holds its last value.
- Reset mid-flight: grant req[1] addr 9, assert reset on the next cycle.
  - No rvalid is ever produced for that read; ptr = 0 and Select = 0 after reset.
- Dropped request: req[2] high 1 cycle while req[0] wins, then req[2] low.
  - req[2] is never granted, and rvalid[2] never asserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes and index types for register-file port arbitration.
// Pure declarations; no logic, no latency, no flow control.
package regfile_pkg;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef logic [1:0] req_idx_t;
  typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: scans from ptr_i upward, first request wins.
// Zero latency; no flow control, caller decides when a grant is consumed.
module rr_picker
  import regfile_pkg::*;
(
  input  logic [3:0] req_i,
  input  req_idx_t   ptr_i,
  output logic [3:0] gnt_o,
  output req_idx_t   idx_o,
  output logic       any_o
);

  req_idx_t cand;

  always_comb begin
    gnt_o = '0;
    idx_o = ptr_i;
    any_o = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_i + 2'(k);
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regread_arbiter.sv
// Shares one register-file read port among four requesters round-robin; grant to data is 2 cycles.
// No stall path: one read per cycle, consumers must take rvalid when it fires.
module regread_arbiter #(
  parameter int NREQ   = regfile_pkg::NREQ,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr,
  output logic [NREQ-1:0]        gnt,
  output logic [ADDR_W-1:0]      Select,
  input  logic [DATA_W-1:0]      MuxOut,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        rvalid
);
  import regfile_pkg::*;

  req_idx_t            ptr_q, ptr_d;
  req_idx_t            owner_q, owner_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   select_q, select_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0]     rvalid_q, rvalid_d;

  logic [NREQ-1:0]     pick_gnt;
  req_idx_t            win_idx;
  logic                pick_any;
  logic                grant_fire;

  rr_picker u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (win_idx),
    .any_o (pick_any)
  );

  // Grants are suppressed while reset is high so nothing is transferred then.
  assign grant_fire = pick_any & ~reset;
  assign gnt        = pick_gnt & {NREQ{~reset}};

  always_comb begin
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    select_d = select_q;
    pend_d   = 1'b0;
    if (grant_fire) begin
      select_d = addr[win_idx*ADDR_W +: ADDR_W];
      owner_d  = win_idx;
      pend_d   = 1'b1;
      ptr_d    = win_idx + 2'd1;
    end
  end

  // Stage 2: capture the mux output for the read issued last cycle.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = '0;
    if (pend_q) begin
      rdata_d           = MuxOut;
      rvalid_d[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      pend_q   <= 1'b0;
      select_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      pend_q   <= pend_d;
      select_q <= select_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign Select = select_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_regread_arbiter.sv
// Directed vector bench for regread_arbiter with a behavioural 32-entry read mux.
module tb_regread_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] addr;
  logic [3:0]  gnt;
  logic [4:0]  Select;
  logic [31:0] MuxOut;
  logic [31:0] rdata;
  logic [3:0]  rvalid;

  logic [31:0] regs [32];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [19:0] addr;
    logic [3:0]  gnt;
    logic [4:0]  sel;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign MuxOut = regs[Select];

  regread_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
    .gnt    (gnt),
    .Select (Select),
    .MuxOut (MuxOut),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  function automatic logic [19:0] mk_addr(int a0, int a1, int a2, int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [31:0] rv_of(int i);
    if (i == 7)  return 32'hDEADBEEF;
    if (i == 31) return 32'hCAFEF00D;
    return 32'h1000_0000 | 32'(i);
  endfunction

  task automatic add(logic rst, logic [3:0] rq, logic [19:0] ad, logic [3:0] g,
                     int sel, logic [3:0] rv, logic [31:0] rd, logic chk);
    vec_t v;
    v.rst = rst; v.req = rq; v.addr = ad; v.gnt = g;
    v.sel = 5'(sel); v.rv = rv; v.rd = rd; v.chk = chk;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_gnt3(output int n);
    n = 0;
    while (n < 6) begin
      @(negedge clk);
      #1;
      if (gnt[3]) break;
      n++;
    end
  endtask

  logic [19:0] a_none, a_r7, a_wrap, a_full, a_r31, a_drop, a_r9;
  int waited;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = rv_of(i);
    reset = 1'b1;
    req   = '0;
    addr  = '0;

    a_none = '0;
    a_r7   = mk_addr(0, 0, 7, 0);
    a_wrap = mk_addr(1, 0, 0, 3);
    a_full = mk_addr(1, 2, 3, 4);
    a_r31  = mk_addr(0, 31, 0, 0);
    a_drop = mk_addr(6, 0, 5, 0);
    a_r9   = mk_addr(0, 9, 0, 0);

    // reset, then single request to reg 7 from requester 2
    add(1, 4'b0000, a_none, 4'b0000, 0,  4'b0000, 32'h0, 0);
    add(1, 4'b0100, a_r7,   4'b0000, 0,  4'b0000, 32'h0, 1);
    add(0, 4'b0100, a_r7,   4'b0100, 0,  4'b0000, 32'h0, 1);
    add(0, 4'b0000, a_r7,   4'b0000, 7,  4'b0000, 32'h0, 1);
    add(0, 4'b0000, a_r7,   4'b0000, 7,  4'b0100, rv_of(7), 1);
    // pointer wrap: req3 alone, then 1001
    add(0, 4'b1000, a_wrap, 4'b1000, 7,  4'b0000, rv_of(7), 1);
    add(0, 4'b1001, a_wrap, 4'b0001, 3,  4'b0000, rv_of(7), 1);
    add(0, 4'b1001, a_wrap, 4'b1000, 1,  4'b1000, rv_of(3), 1);
    add(0, 4'b0000, a_wrap, 4'b0000, 3,  4'b0001, rv_of(1), 1);
    add(0, 4'b0000, a_wrap, 4'b0000, 3,  4'b1000, rv_of(3), 1);
    // full contention, 8 cycles
    add(0, 4'b1111, a_full, 4'b0001, 3,  4'b0000, rv_of(3), 1);
    add(0, 4'b1111, a_full, 4'b0010, 1,  4'b0000, rv_of(3), 1);
    add(0, 4'b1111, a_full, 4'b0100, 2,  4'b0001, rv_of(1), 1);
    add(0, 4'b1111, a_full, 4'b1000, 3,  4'b0010, rv_of(2), 1);
    add(0, 4'b1111, a_full, 4'b0001, 4,  4'b0100, rv_of(3), 1);
    add(0, 4'b1111, a_full, 4'b0010, 1,  4'b1000, rv_of(4), 1);
    add(0, 4'b1111, a_full, 4'b0100, 2,  4'b0001, rv_of(1), 1);
    add(0, 4'b1111, a_full, 4'b1000, 3,  4'b0010, rv_of(2), 1);
    add(0, 4'b0000, a_full, 4'b0000, 4,  4'b0100, rv_of(3), 1);
    add(0, 4'b0000, a_full, 4'b0000, 4,  4'b1000, rv_of(4), 1);
    add(0, 4'b0000, a_full, 4'b0000, 4,  4'b0000, rv_of(4), 1);
    // read reg 31, then idle 5 cycles
    add(0, 4'b0010, a_r31,  4'b0010, 4,  4'b0000, rv_of(4), 1);
    add(0, 4'b0000, a_r31,  4'b0000, 31, 4'b0000, rv_of(4), 1);
    add(0, 4'b0000, a_r31,  4'b0000, 31, 4'b0010, rv_of(31), 1);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0000, a_none, 4'b0000, 31, 4'b0000, rv_of(31), 1);
    // dropped request: move ptr to 3, then req 0101 lets 0 win and 2 drops
    add(0, 4'b0100, a_drop, 4'b0100, 31, 4'b0000, rv_of(31), 1);
    add(0, 4'b0101, a_drop, 4'b0001, 5,  4'b0000, rv_of(31), 1);
    add(0, 4'b0000, a_drop, 4'b0000, 6,  4'b0100, rv_of(5), 1);
    add(0, 4'b0000, a_drop, 4'b0000, 6,  4'b0001, rv_of(6), 1);
    add(0, 4'b0000, a_drop, 4'b0000, 6,  4'b0000, rv_of(6), 1);
    // reset mid-flight after granting req1 addr 9
    add(0, 4'b0010, a_r9,   4'b0010, 6,  4'b0000, rv_of(6), 1);
    add(1, 4'b0000, a_r9,   4'b0000, 9,  4'b0000, rv_of(6), 1);
    add(0, 4'b0000, a_r9,   4'b0000, 0,  4'b0000, 32'h0, 1);
    add(0, 4'b0000, a_r9,   4'b0000, 0,  4'b0000, 32'h0, 1);
    add(0, 4'b1111, a_full, 4'b0001, 0,  4'b0000, 32'h0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      req   = vecs[i].req;
      addr  = vecs[i].addr;
      #1;
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      if (vecs[i].chk) begin
        check($sformatf("v%0d select", i), 32'(Select), 32'(vecs[i].sel));
        check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
        check($sformatf("v%0d rdata", i), rdata, vecs[i].rd);
      end
    end

    // ptr now 1: requester 3 waits behind 1 and 2
    req = 4'b1111;
    wait_gnt3(waited);
    check("wait_behind_two", 32'(waited), 32'd2);
    // ptr wrapped to 0: requester 3 holding req sees the worst-case 3-cycle wait
    wait_gnt3(waited);
    check("worst_case_wait", 32'(waited), 32'd3);

    @(negedge clk);
    req = '0;
    @(negedge clk);
    #1;
    check("final_gnt_idle", 32'(gnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
